// File: rtl/vga_scan_generator.sv
// rtl/vga_scan_generator.sv - VGA raster timing, pixel address stream and colour return path
// Counters advance on DOWNCOUNTER edges; colour/sync outputs lag the address by one pixel.
module vga_scan_generator #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DOWNCOUNTER,
  input  logic [7:0] COLOUR_IN,
  output logic [9:0] ADDRH,
  output logic [8:0] ADDRV,
  output logic [7:0] COLOUR_OUT,
  output logic       HS,
  output logic       VS,
  output logic       REFRESH
);

  localparam logic [9:0] H_LAST       = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST       = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_END    = 10'(V_VIS);
  localparam logic [9:0] H_SYNC_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [9:0] hcnt_next;
  logic [9:0] vcnt_next;
  logic       pix_visible;
  logic       pix_hsync;
  logic       pix_vsync;
  logic       frame_blank_start;

  always_comb begin
    hcnt_next = hcnt + 10'd1;
    vcnt_next = vcnt;
    if (hcnt == H_LAST) begin
      hcnt_next = 10'd0;
      vcnt_next = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end
    // Region flags describe the pixel held in the counters before this edge.
    pix_visible       = (hcnt < H_VIS_END) && (vcnt < V_VIS_END);
    pix_hsync         = (hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END);
    pix_vsync         = (vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END);
    frame_blank_start = (hcnt_next == 10'd0) && (vcnt_next == V_VIS_END);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hcnt       <= 10'd0;
      vcnt       <= 10'd0;
      ADDRH      <= 10'd0;
      ADDRV      <= 9'd0;
      COLOUR_OUT <= 8'h00;
      HS         <= 1'b1;
      VS         <= 1'b1;
      REFRESH    <= 1'b0;
    end else begin
      // REFRESH is one CLK wide regardless of the enable pattern.
      REFRESH <= 1'b0;
      if (DOWNCOUNTER) begin
        hcnt       <= hcnt_next;
        vcnt       <= vcnt_next;
        ADDRH      <= (hcnt_next < H_VIS_END) ? hcnt_next : 10'd0;
        ADDRV      <= (vcnt_next < V_VIS_END) ? vcnt_next[8:0] : 9'd0;
        COLOUR_OUT <= pix_visible ? COLOUR_IN : 8'h00;
        HS         <= ~pix_hsync;
        VS         <= ~pix_vsync;
        REFRESH    <= frame_blank_start;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_generator.sv
// tb/tb_vga_scan_generator.sv - randomized self-checking bench for vga_scan_generator
// Uses a shrunken raster so several full frames fit in a short run.
module tb_vga_scan_generator;
  localparam int HV = 20, HF = 3, HSY = 5, HB = 4;
  localparam int VV = 12, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FRAME = HT * VT;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       DOWNCOUNTER = 1'b0;
  logic [7:0] COLOUR_IN = 8'h00;
  logic [9:0] ADDRH;
  logic [8:0] ADDRV;
  logic [7:0] COLOUR_OUT;
  logic       HS, VS, REFRESH;

  logic mode_ff = 1'b0;
  logic last_en = 1'b0;
  int   n = 0;
  int   errors = 0;
  int   checks = 0;

  vga_scan_generator #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .CLK(CLK), .RESET(RESET), .DOWNCOUNTER(DOWNCOUNTER), .COLOUR_IN(COLOUR_IN),
    .ADDRH(ADDRH), .ADDRV(ADDRV), .COLOUR_OUT(COLOUR_OUT),
    .HS(HS), .VS(VS), .REFRESH(REFRESH)
  );

  always #5 CLK = ~CLK;

  // Client: registers a colour for the presented address on non-enable edges.
  always @(posedge CLK)
    if (!DOWNCOUNTER) COLOUR_IN <= mode_ff ? 8'hFF : ADDRH[7:0];

  // Reference model: position of pixel k counted in enable edges since reset.
  function automatic int ph(int k); return (k % FRAME) % HT; endfunction
  function automatic int pv(int k); return (k % FRAME) / HT; endfunction
  function automatic logic [9:0] e_addrh(int k);
    return (ph(k) < HV) ? 10'(ph(k)) : 10'd0;
  endfunction
  function automatic logic [8:0] e_addrv(int k);
    return (pv(k) < VV) ? 9'(pv(k)) : 9'd0;
  endfunction
  function automatic logic e_hs(int k);
    if (k == 0) return 1'b1;
    return !(ph(k-1) >= HV + HF && ph(k-1) < HV + HF + HSY);
  endfunction
  function automatic logic e_vs(int k);
    if (k == 0) return 1'b1;
    return !(pv(k-1) >= VV + VF && pv(k-1) < VV + VF + VSY);
  endfunction
  function automatic logic [7:0] e_col(int k, logic ff);
    if (k == 0) return 8'h00;
    if (ph(k-1) < HV && pv(k-1) < VV) return ff ? 8'hFF : 8'(ph(k-1));
    return 8'h00;
  endfunction
  function automatic logic e_ref(int k, logic en);
    return en && (k > 0) && ((k % FRAME) == VV * HT);
  endfunction

  task automatic step(input logic en);
    DOWNCOUNTER = en;
    @(posedge CLK);
    #1;
    last_en = en;
    if (en && !RESET) n++;
  endtask

  task automatic test_reset;
    while (n < HT * 3 + HV + HF + 1) begin step(1'b0); step(1'b1); end
    checks++;
    if (HS !== e_hs(n) || ADDRV !== e_addrv(n)) begin
      errors++; $display("FAIL pre_reset hs=%b addrv=%0d exp hs=%b addrv=%0d", HS, ADDRV, e_hs(n), e_addrv(n));
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (ADDRH !== 10'd0 || ADDRV !== 9'd0 || COLOUR_OUT !== 8'h00 || HS !== 1'b1 || VS !== 1'b1 || REFRESH !== 1'b0) begin
      errors++; $display("FAIL async_reset got %0d/%0d/%h/%b/%b/%b exp 0/0/00/1/1/0", ADDRH, ADDRV, COLOUR_OUT, HS, VS, REFRESH);
    end
    n = 0;
    step(1'b1); step(1'b0);
    checks++;
    if (ADDRH !== 10'd0 || HS !== 1'b1) begin
      errors++; $display("FAIL reset_hold addrh=%0d hs=%b exp 0/1", ADDRH, HS);
    end
    RESET = 1'b0;
    step(1'b0); step(1'b1);
    checks++;
    if (ADDRH !== 10'd1 || ADDRV !== 9'd0 || COLOUR_OUT !== 8'h00 || HS !== 1'b1 || VS !== 1'b1) begin
      errors++; $display("FAIL first_edge got %0d/%0d/%h/%b/%b exp 1/0/00/1/1", ADDRH, ADDRV, COLOUR_OUT, HS, VS);
    end
  endtask

  task automatic test_line_frame;
    int cyc = 0, hs_fall = -1, vs_fall = -1, ref_t = -1, pulses = 0;
    logic hs_p = HS, vs_p = VS;
    mode_ff = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      for (int e = 0; e < 2; e++) begin
        step(e == 1);
        cyc++;
        checks++;
        if (ADDRH !== e_addrh(n) || ADDRV !== e_addrv(n)) begin
          errors++; $display("FAIL line_addr n=%0d got %0d,%0d exp %0d,%0d", n, ADDRH, ADDRV, e_addrh(n), e_addrv(n));
        end
        checks++;
        if (HS !== e_hs(n) || VS !== e_vs(n) || COLOUR_OUT !== e_col(n, 1'b0)) begin
          errors++; $display("FAIL line_stage2 n=%0d got %b/%b/%h exp %b/%b/%h", n, HS, VS, COLOUR_OUT, e_hs(n), e_vs(n), e_col(n, 1'b0));
        end
        checks++;
        if (REFRESH !== e_ref(n, last_en)) begin
          errors++; $display("FAIL line_refresh n=%0d got %b exp %b", n, REFRESH, e_ref(n, last_en));
        end
        if (hs_p && !HS) begin
          if (hs_fall >= 0) begin
            checks++;
            if (cyc - hs_fall != 2 * HT) begin errors++; $display("FAIL hs_period got %0d exp %0d", cyc - hs_fall, 2 * HT); end
          end
          hs_fall = cyc;
        end
        if (!hs_p && HS && hs_fall >= 0) begin
          checks++;
          if (cyc - hs_fall != 2 * HSY) begin errors++; $display("FAIL hs_width got %0d exp %0d", cyc - hs_fall, 2 * HSY); end
        end
        if (vs_p && !VS) begin
          if (vs_fall >= 0) begin
            checks++;
            if (cyc - vs_fall != 2 * FRAME) begin errors++; $display("FAIL vs_period got %0d exp %0d", cyc - vs_fall, 2 * FRAME); end
          end
          vs_fall = cyc;
        end
        if (!vs_p && VS && vs_fall >= 0) begin
          checks++;
          if (cyc - vs_fall != 2 * VSY * HT) begin errors++; $display("FAIL vs_width got %0d exp %0d", cyc - vs_fall, 2 * VSY * HT); end
        end
        if (REFRESH) begin
          pulses++;
          if (ref_t >= 0) begin
            checks++;
            if (cyc - ref_t != 2 * FRAME) begin errors++; $display("FAIL refresh_period got %0d exp %0d", cyc - ref_t, 2 * FRAME); end
          end
          ref_t = cyc;
        end
        hs_p = HS; vs_p = VS;
      end
    end
    checks++;
    if (pulses != 2) begin errors++; $display("FAIL refresh_count got %0d exp 2", pulses); end
  endtask

  task automatic test_blanking;
    mode_ff = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0); step(1'b1);
      checks++;
      if (COLOUR_OUT !== e_col(n, 1'b1)) begin
        errors++; $display("FAIL blank_colour n=%0d got %h exp %h", n, COLOUR_OUT, e_col(n, 1'b1));
      end
    end
    mode_ff = 1'b0;
  endtask

  task automatic test_hold;
    int guard = 0;
    step(1'b0);
    while ((n % FRAME) != VV * HT && guard < 2 * FRAME) begin step(1'b0); step(1'b1); guard++; end
    checks++;
    if (REFRESH !== 1'b1 || guard >= 2 * FRAME) begin
      errors++; $display("FAIL hold_refresh_start got %b exp 1 guard=%0d", REFRESH, guard);
    end
    for (int i = 0; i < 100; i++) begin
      step(1'b0);
      checks++;
      if (ADDRH !== e_addrh(n) || ADDRV !== e_addrv(n) || HS !== e_hs(n) || VS !== e_vs(n) ||
          COLOUR_OUT !== e_col(n, 1'b0) || REFRESH !== 1'b0) begin
        errors++; $display("FAIL hold_frozen cyc=%0d got %0d/%0d/%b/%b/%h/%b", i, ADDRH, ADDRV, HS, VS, COLOUR_OUT, REFRESH);
      end
    end
    for (int i = 0; i < 2 * HT; i++) begin
      step(1'b0); step(1'b1);
      checks++;
      if (ADDRH !== e_addrh(n) || ADDRV !== e_addrv(n) || HS !== e_hs(n) || VS !== e_vs(n) ||
          COLOUR_OUT !== e_col(n, 1'b0)) begin
        errors++; $display("FAIL hold_resume n=%0d got %0d/%0d/%b/%b/%h", n, ADDRH, ADDRV, HS, VS, COLOUR_OUT);
      end
    end
  endtask

  task automatic test_random_enable;
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)));
      checks++;
      if (ADDRH !== e_addrh(n) || ADDRV !== e_addrv(n) || HS !== e_hs(n) || VS !== e_vs(n)) begin
        errors++; $display("FAIL rand_raster n=%0d got %0d/%0d/%b/%b exp %0d/%0d/%b/%b", n, ADDRH, ADDRV, HS, VS,
                           e_addrh(n), e_addrv(n), e_hs(n), e_vs(n));
      end
      checks++;
      if (REFRESH !== e_ref(n, last_en)) begin
        errors++; $display("FAIL rand_refresh n=%0d got %b exp %b", n, REFRESH, e_ref(n, last_en));
      end
    end
  endtask

  initial begin
    repeat (3) step(1'b0);
    RESET = 1'b0;
    n = 0;
    checks++;
    if (ADDRH !== 10'd0 || ADDRV !== 9'd0 || COLOUR_OUT !== 8'h00 || HS !== 1'b1 || VS !== 1'b1 || REFRESH !== 1'b0) begin
      errors++; $display("FAIL reset_state got %0d/%0d/%h/%b/%b/%b", ADDRH, ADDRV, COLOUR_OUT, HS, VS, REFRESH);
    end
    test_reset;
    test_line_frame;
    test_blanking;
    test_hold;
    test_random_enable;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
